updown_btn_conditioner: RTL and testbench
=========================================

Name: updown_btn_conditioner

Overview:
- Front-end stage for the up/down counter: takes two raw, asynchronous, bouncing push-button inputs and produces clean, synchronous signals.
- Outputs per button:
  - a debounced level, which drives the counter's level-sensitive up/down inputs;
  - a one-cycle press pulse, for pulse-driven consumers.
- Channels are independent except for the simultaneous-press rule.

Parameters:
- DEBOUNCE_CYCLES, 16: consecutive stable synchronized samples needed to accept a level change. Legal range 2 to 65535.
- REPEAT_DELAY, 500: cycles a button must be held before the first auto-repeat pulse. Used only with the optional feature.
- REPEAT_PERIOD, 100: cycles between auto-repeat pulses after the first. Used only with the optional feature. Must be at least 1.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- up_btn  in  1  raw up button, asynchronous, active-high.
- down_btn  in  1  raw down button, asynchronous, active-high.
- up  out  1  debounced up level.
- down  out  1  debounced down level.
- up_pulse  out  1  one-cycle pulse per accepted up press (and per repeat).
- down_pulse  out  1  one-cycle pulse per accepted down press (and per repeat).
- conflict  out  1  high while both debounced levels are high.

Behaviour:
- Reset (reset=0, asserted asynchronously): all outputs 0; synchronizers 0; counters 0; both FSMs in IDLE. Release is sampled on clk like any other cycle.
- Synchronizer: each raw input passes through 2 flops (s1 then s2). Only s2 is used downstream.
- Per-channel FSM, state encodings internal:
  - IDLE (level=0): s2=1 -> ARMING, cnt=0.
  - ARMING (level=0): s2=0 -> IDLE. s2=1 and cnt<DEBOUNCE_CYCLES-1 -> cnt+1. s2=1 and cnt==DEBOUNCE_CYCLES-1 -> PRESSED, level=1, pulse=1.
  - PRESSED (level=1): s2=0 -> RELEASING, cnt=0.
  - RELEASING (level=1): s2=1 -> PRESSED. This returns with no new pulse, and the repeat timer keeps its value. s2=0 and cnt==DEBOUNCE_CYCLES-1 -> IDLE, level=0.
- All outputs are registered.
- Latency: with a raw edge stable before clock edge 1, the level changes at edge DEBOUNCE_CYCLES+3. The press pulse is high for exactly the cycle after that edge.
- Glitch rejection: any bounce shorter than DEBOUNCE_CYCLES synchronized samples never changes the level and never pulses. The debounce count restarts from 0 on every bounce.
- Counter width: ceil(log2(DEBOUNCE_CYCLES)). The counter saturates and never wraps.
- Simultaneous press:
  - conflict = up & down, registered alongside the levels.
  - Any pulse (press or repeat) that would fire while the other channel's level is 1, or in the same cycle the other level rises, is suppressed. This includes both pulses when both levels rise in the same cycle.
  - Levels themselves are never suppressed.
- Reset mid-debounce or mid-hold: everything returns to the reset values immediately. After release, a still-held button must be re-debounced and then produces a fresh press pulse.

Optional Feature:
- Macro: UPDOWN_AUTOREPEAT_EN.
- Defined:
  - Each channel has a hold timer that is cleared when the channel enters PRESSED from ARMING.
  - After REPEAT_DELAY cycles in PRESSED/RELEASING, one repeat pulse is emitted, then one every REPEAT_PERIOD cycles while level=1.
  - The timer stops and clears when level falls.
  - Repeat pulses obey the conflict suppression rule.
- Undefined: no hold timers are instantiated; exactly one pulse per accepted press.

Test Plan:
- Reset check: reset=0 with up_btn=1 -> all outputs 0. Release reset, then hold up_btn=1 with DEBOUNCE_CYCLES=4 -> up=1 at edge 7 after release, up_pulse high for exactly 1 cycle, down and down_pulse stay 0.
- Bounce rejection: DEBOUNCE_CYCLES=4, up_btn toggles 1,0,1,0 every 2 cycles then holds 1 -> up rises exactly 7 edges after the final rising transition, with a single up_pulse. Releasing with 3-cycle glitches keeps up=1.
- Simultaneous press: up_btn and down_btn rise on the same cycle -> up=down=1 and conflict=1 on the same edge, zero pulses. Releasing down -> conflict=0 after debounce, and no up_pulse is generated.
- Reset mid-operation: assert reset for 1 cycle while in ARMING with cnt=2 -> outputs 0 immediately. The held button needs a full DEBOUNCE_CYCLES+3 edges again, then pulses once.
- Auto-repeat (UPDOWN_AUTOREPEAT_EN, DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=5), hold down_btn for 40 cycles -> pulses at the press, +10, +15, +20, ...; none after down falls.
- Auto-repeat disabled, same stimulus -> exactly 1 down_pulse.

Source files
------------

// File: rtl/updown_btn_conditioner.sv
// updown_btn_conditioner: two-channel push-button front end for the up/down
// counter. Each raw button is synchronised, debounced into a level and turned
// into a one-cycle press pulse; pulses are withheld while both buttons are
// down. Optional auto-repeat is compiled in with `define UPDOWN_AUTOREPEAT_EN.
// Channel index 0 is the up button, index 1 is the down button.
module updown_btn_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned REPEAT_DELAY    = 500,
    parameter int unsigned REPEAT_PERIOD   = 100
) (
    input  logic clk,
    input  logic reset,
    input  logic up_btn,
    input  logic down_btn,
    output logic up,
    output logic down,
    output logic up_pulse,
    output logic down_pulse,
    output logic conflict
);

    localparam int unsigned      CNT_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 65535) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES must be in 2..65535");
    end
    if (REPEAT_PERIOD < 1 || REPEAT_DELAY < 1) begin : g_bad_repeat
        $error("REPEAT_DELAY and REPEAT_PERIOD must be at least 1");
    end

    typedef enum logic [1:0] {
        IDLE,
        ARMING,
        PRESSED,
        RELEASING
    } state_e;

    logic [1:0]       s1_q;
    logic [1:0]       s2_q;
    state_e           st_q  [2];
    state_e           st_d  [2];
    logic [CNT_W-1:0] cnt_q [2];
    logic [CNT_W-1:0] cnt_d [2];
    logic [1:0]       lvl_q;
    logic [1:0]       lvl_d;
    logic [1:0]       press;
    logic [1:0]       fire;
    logic [1:0]       busy;
    logic [1:0]       pulse_q;
    logic [1:0]       pulse_d;
    logic             conflict_q;
    logic             conflict_d;

    // Two-flop synchroniser per raw button; only the second stage is used.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= {down_btn, up_btn};
            s2_q <= s1_q;
        end
    end

    // Debounce next-state: a level change needs an unbroken run of samples
    // at the new value; any disagreeing sample abandons the attempt.
    always_comb begin
        for (int unsigned c = 0; c < 2; c++) begin
            st_d[c]  = st_q[c];
            cnt_d[c] = cnt_q[c];
            press[c] = 1'b0;
            unique case (st_q[c])
                IDLE: begin
                    if (s2_q[c]) begin
                        st_d[c]  = ARMING;
                        cnt_d[c] = '0;
                    end
                end
                ARMING: begin
                    if (!s2_q[c]) begin
                        st_d[c] = IDLE;
                    end else if (cnt_q[c] == CNT_MAX) begin
                        st_d[c]  = PRESSED;
                        press[c] = 1'b1;
                    end else begin
                        cnt_d[c] = cnt_q[c] + 1'b1;
                    end
                end
                PRESSED: begin
                    if (!s2_q[c]) begin
                        st_d[c]  = RELEASING;
                        cnt_d[c] = '0;
                    end
                end
                RELEASING: begin
                    if (s2_q[c]) begin
                        st_d[c] = PRESSED;
                    end else if (cnt_q[c] == CNT_MAX) begin
                        st_d[c] = IDLE;
                    end else begin
                        cnt_d[c] = cnt_q[c] + 1'b1;
                    end
                end
                default: begin
                    st_d[c] = IDLE;
                end
            endcase
            lvl_d[c] = (st_d[c] == PRESSED) || (st_d[c] == RELEASING);
        end
    end

`ifdef UPDOWN_AUTOREPEAT_EN
    localparam int unsigned      RPT_MAX     = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY
                                                                              : REPEAT_PERIOD;
    localparam int unsigned      TMR_W       = $clog2(RPT_MAX + 1);
    localparam logic [TMR_W-1:0] DELAY_LAST  = TMR_W'(REPEAT_DELAY - 1);
    localparam logic [TMR_W-1:0] PERIOD_LAST = TMR_W'(REPEAT_PERIOD - 1);

    logic [TMR_W-1:0] tmr_q [2];
    logic [TMR_W-1:0] tmr_d [2];
    logic [1:0]       rep_q;
    logic [1:0]       rep_d;
    logic [1:0]       rpt;

    // Hold timer: counts cycles at level 1, first wrap after the initial
    // delay, later wraps every period; cleared on a fresh press or a release.
    always_comb begin
        for (int unsigned c = 0; c < 2; c++) begin
            tmr_d[c] = tmr_q[c];
            rep_d[c] = rep_q[c];
            rpt[c]   = 1'b0;
            if (press[c] || !lvl_d[c]) begin
                tmr_d[c] = '0;
                rep_d[c] = 1'b0;
            end else if (lvl_q[c]) begin
                if (tmr_q[c] == (rep_q[c] ? PERIOD_LAST : DELAY_LAST)) begin
                    rpt[c]   = 1'b1;
                    tmr_d[c] = '0;
                    rep_d[c] = 1'b1;
                end else begin
                    tmr_d[c] = tmr_q[c] + 1'b1;
                end
            end
        end
    end

    // Hold timer registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned c = 0; c < 2; c++) begin
                tmr_q[c] <= '0;
            end
            rep_q <= '0;
        end else begin
            for (int unsigned c = 0; c < 2; c++) begin
                tmr_q[c] <= tmr_d[c];
            end
            rep_q <= rep_d;
        end
    end

    assign fire = press | rpt;
`else
    assign fire = press;
`endif

    // A pulse is withheld if the opposite level is high now or rises this cycle.
    always_comb begin
        busy       = lvl_q | lvl_d;
        pulse_d    = fire & ~{busy[0], busy[1]};
        conflict_d = lvl_d[0] & lvl_d[1];
    end

    // Debounce FSM state, counters and all registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned c = 0; c < 2; c++) begin
                st_q[c]  <= IDLE;
                cnt_q[c] <= '0;
            end
            lvl_q      <= '0;
            pulse_q    <= '0;
            conflict_q <= 1'b0;
        end else begin
            for (int unsigned c = 0; c < 2; c++) begin
                st_q[c]  <= st_d[c];
                cnt_q[c] <= cnt_d[c];
            end
            lvl_q      <= lvl_d;
            pulse_q    <= pulse_d;
            conflict_q <= conflict_d;
        end
    end

    assign up         = lvl_q[0];
    assign down       = lvl_q[1];
    assign up_pulse   = pulse_q[0];
    assign down_pulse = pulse_q[1];
    assign conflict   = conflict_q;

endmodule

// File: tb/tb_updown_btn_conditioner.sv
// Testbench for updown_btn_conditioner: directed button sequences, a
// run-length based reference model compared every cycle, plus literal checks.
module tb_updown_btn_conditioner;

    localparam int DB = 4;
    localparam int RD = 10;
    localparam int RP = 5;

    logic clk      = 1'b0;
    logic reset    = 1'b0;
    logic up_btn   = 1'b0;
    logic down_btn = 1'b0;
    logic up, down, up_pulse, down_pulse, conflict;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;
    int n_up   = 0;
    int n_dn   = 0;

    always #5 clk = ~clk;

    updown_btn_conditioner #(
        .DEBOUNCE_CYCLES(DB),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .up_btn    (up_btn),
        .down_btn  (down_btn),
        .up        (up),
        .down      (down),
        .up_pulse  (up_pulse),
        .down_pulse(down_pulse),
        .conflict  (conflict)
    );

    // Reference model: raw inputs reach the decision logic two edges late;
    // a level flips after DB+1 consecutive disagreeing samples.
    logic [1:0] m_q [$] = '{2'b00, 2'b00};
    logic [1:0] m_lvl   = '0;
    logic [1:0] m_pulse = '0;
    logic       m_conf  = 1'b0;
    int         m_run [2] = '{0, 0};
    int         m_age [2] = '{0, 0};

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_q     = '{2'b00, 2'b00};
            m_lvl   <= '0;
            m_pulse <= '0;
            m_conf  <= 1'b0;
            m_run   <= '{0, 0};
            m_age   <= '{0, 0};
        end else begin : model_step
            logic [1:0] seen, nw, fire, busy;
            int run_n [2];
            int age_n [2];
            seen = m_q.pop_front();
            m_q.push_back({down_btn, up_btn});
            nw   = m_lvl;
            fire = '0;
            for (int c = 0; c < 2; c++) begin
                run_n[c] = (seen[c] != m_lvl[c]) ? m_run[c] + 1 : 0;
                if (run_n[c] == DB + 1) begin
                    nw[c]    = seen[c];
                    run_n[c] = 0;
                end
                age_n[c] = 0;
                if (nw[c] && !m_lvl[c]) begin
                    fire[c] = 1'b1;
                end else if (nw[c]) begin
                    age_n[c] = m_age[c] + 1;
`ifdef UPDOWN_AUTOREPEAT_EN
                    if (age_n[c] >= RD && (age_n[c] - RD) % RP == 0) fire[c] = 1'b1;
`endif
                end
            end
            busy     = m_lvl | nw;
            m_pulse <= fire & ~{busy[0], busy[1]};
            m_lvl   <= nw;
            m_conf  <= nw[0] & nw[1];
            m_run   <= run_n;
            m_age   <= age_n;
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            checks++;
            if ({up, down, up_pulse, down_pulse, conflict} !==
                {m_lvl[0], m_lvl[1], m_pulse[0], m_pulse[1], m_conf}) begin
                errors++;
                $display("FAIL model_cmp t=%0t got {up,down,upp,dnp,conf}=%b expected=%b", $time,
                         {up, down, up_pulse, down_pulse, conflict},
                         {m_lvl[0], m_lvl[1], m_pulse[0], m_pulse[1], m_conf});
            end
        end
    end

    always @(negedge clk) begin
        if (up_pulse === 1'b1) n_up++;
        if (down_pulse === 1'b1) n_dn++;
    end

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Edges until the selected output (0 up, 1 down, 2 conflict) equals val; -1 on timeout.
    task automatic wait_out(input int which, input logic val, output int edges);
        logic v;
        edges = -1;
        for (int i = 1; i <= 64; i++) begin
            @(negedge clk);
            v = (which == 0) ? up : (which == 1) ? down : conflict;
            if (v === val) begin
                edges = i;
                return;
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int e, u0, d0;
        int exp_rep;

        // Reset with a held button: everything stays at zero.
        reset  = 1'b0;
        up_btn = 1'b1;
        idle(3);
        check("reset_outputs", int'({up, down, up_pulse, down_pulse, conflict}), 0);
        chk_en = 1'b1;

        // Release reset with up held: level at edge DB+3, one pulse.
        u0 = n_up; d0 = n_dn;
        reset = 1'b1;
        wait_out(0, 1'b1, e);
        check("first_press_latency", e, DB + 3);
        idle(2);
        check("first_press_up_pulses", n_up - u0, 1);
        check("first_press_down_pulses", n_dn - d0, 0);
        up_btn = 1'b0;
        wait_out(0, 1'b0, e);
        check("first_release_latency", e, DB + 3);
        idle(4);

        // Bounce on press, then 3-cycle glitches while held.
        u0 = n_up;
        for (int k = 0; k < 4; k++) begin
            up_btn = (k % 2 == 0);
            idle(2);
        end
        up_btn = 1'b1;
        wait_out(0, 1'b1, e);
        check("bounce_press_latency", e, DB + 3);
        for (int g = 0; g < 2; g++) begin
            up_btn = 1'b0;
            idle(3);
            up_btn = 1'b1;
            idle(4);
        end
        check("glitch_keeps_level", int'(up), 1);
        check("bounce_up_pulses", n_up - u0, 1);
        up_btn = 1'b0;
        wait_out(0, 1'b0, e);
        check("bounce_release_latency", e, DB + 3);
        idle(4);

        // Simultaneous press: levels and conflict together, no pulses.
        u0 = n_up; d0 = n_dn;
        up_btn   = 1'b1;
        down_btn = 1'b1;
        wait_out(2, 1'b1, e);
        check("conflict_latency", e, DB + 3);
        check("both_levels_high", int'({up, down}), 3);
        down_btn = 1'b0;
        wait_out(2, 1'b0, e);
        check("conflict_clear_latency", e, DB + 3);
        idle(2);
        check("simul_up_pulses", n_up - u0, 0);
        check("simul_down_pulses", n_dn - d0, 0);
        up_btn = 1'b0;
        wait_out(0, 1'b0, e);
        check("simul_up_release", e, DB + 3);
        idle(20);

        // Reset while ARMING with cnt=2: full re-debounce and a fresh pulse.
        up_btn = 1'b1;
        idle(5);
        reset = 1'b0;
        #1;
        check("midreset_outputs", int'({up, down, up_pulse, down_pulse, conflict}), 0);
        @(negedge clk);
        u0 = n_up;
        reset = 1'b1;
        wait_out(0, 1'b1, e);
        check("midreset_relatency", e, DB + 3);
        idle(2);
        check("midreset_up_pulses", n_up - u0, 1);
        up_btn = 1'b0;
        wait_out(0, 1'b0, e);
        idle(20);

        // Long hold of down for 40 cycles.
        u0 = n_up; d0 = n_dn;
        down_btn = 1'b1;
        idle(40);
        down_btn = 1'b0;
        idle(20);
`ifdef UPDOWN_AUTOREPEAT_EN
        exp_rep = 7;
`else
        exp_rep = 1;
`endif
        check("hold_down_pulses", n_dn - d0, exp_rep);
        check("hold_up_pulses", n_up - u0, 0);
        check("hold_down_released", int'(down), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
